rf_write_arbiter: RTL and testbench

- Write-side master for the 32x32 register file; the sole driver of its single write port (regwrite, writereg_addr, writedata).
- Merges two writeback sources:
  - the in-order pipeline writeback (ALU/load), which never stalls;
  - the long-latency unit (mul/div) result stream, which uses a valid/ready handshake.
- Also tracks registers with pending long-latency writes (busy_mask) for the hazard unit.
- Raises a starvation stall request when pipeline traffic blocks long-latency results.

---
 rtl/rf_write_arbiter_pkg.sv | 20 ++
 rtl/rf_wb_fifo.sv | 47 ++++
 rtl/rf_write_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// rtl/rf_write_arbiter_pkg.sv - shared types and widths for the register-file write arbiter
package rf_write_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int RA_W     = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [RA_W-1:0] addr;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_PIPE,
        SEL_FIFO,
        SEL_BYPASS
    } wb_sel_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - small synchronous FIFO holding pending long-latency writebacks
module rf_wb_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - single write-port master merging pipeline and long-latency writebacks
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_wen,
    input  logic [RA_W-1:0]      pipe_waddr,
    input  logic [XLEN-1:0]      pipe_wdata,
    input  logic                 issue_valid,
    input  logic [RA_W-1:0]      issue_addr,
    input  logic                 lu_valid,
    output logic                 lu_ready,
    input  logic [RA_W-1:0]      lu_waddr,
    input  logic [XLEN-1:0]      lu_wdata,
    output logic                 regwrite,
    output logic [RA_W-1:0]      writereg_addr,
    output logic [XLEN-1:0]      writedata,
    output logic [NUM_REGS-1:0]  busy_mask,
    output logic                 stall_req
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM - 1);

    wb_entry_t          fifo_head;
    wb_entry_t          lu_entry;
    wb_entry_t          emit_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW:0]        fifo_count;
    logic               fifo_push;
    logic               fifo_pop;
    logic               pipe_req;
    logic               lu_accept_nz;
    wb_sel_t            sel;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [SW-1:0]      starve_cnt;

    assign lu_entry     = '{addr: lu_waddr, data: lu_wdata};
    assign lu_ready     = (32'(fifo_count) < FIFO_DEPTH);
    assign pipe_req     = pipe_wen && (pipe_waddr != '0);
    // x0 results still complete the handshake but are dropped here.
    assign lu_accept_nz = lu_valid && lu_ready && (lu_waddr != '0);

    always_comb begin
        sel = SEL_NONE;
        if (pipe_req)
            sel = SEL_PIPE;
        else if (!fifo_empty)
            sel = SEL_FIFO;
        else if (lu_accept_nz)
            sel = SEL_BYPASS;
    end

    assign fifo_pop   = (sel == SEL_FIFO);
    assign fifo_push  = lu_accept_nz && (sel != SEL_BYPASS) && !fifo_full;
    assign emit_entry = (sel == SEL_FIFO) ? fifo_head : lu_entry;

    always_comb begin
        busy_nxt = busy_mask;
        if (sel == SEL_FIFO || sel == SEL_BYPASS)
            busy_nxt[emit_entry.addr] = 1'b0;
        // Applied after the clear so a same-cycle re-issue keeps the bit set.
        if (issue_valid && issue_addr != '0)
            busy_nxt[issue_addr] = 1'b1;
    end

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (lu_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite      <= 1'b0;
            writereg_addr <= '0;
            writedata     <= '0;
            busy_mask     <= '0;
        end else begin
            busy_mask <= busy_nxt;
            case (sel)
                SEL_PIPE: begin
                    regwrite      <= 1'b1;
                    writereg_addr <= pipe_waddr;
                    writedata     <= pipe_wdata;
                end
                SEL_FIFO, SEL_BYPASS: begin
                    regwrite      <= 1'b1;
                    writereg_addr <= emit_entry.addr;
                    writedata     <= emit_entry.data;
                end
                default: regwrite <= 1'b0;
            endcase
        end
    end

    // Starvation: count cycles a queued result loses the slot to the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            if (fifo_pop || fifo_empty)
                starve_cnt <= '0;
            else if (sel == SEL_PIPE && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;

            if (fifo_pop)
                stall_req <= 1'b0;
            else if (starve_cnt == STARVE_MAX && !fifo_empty)
                stall_req <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed table-driven bench for rf_write_arbiter
module tb_rf_write_arbiter;
    import rf_write_arbiter_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 pipe_wen = 1'b0;
    logic [RA_W-1:0]      pipe_waddr = '0;
    logic [XLEN-1:0]      pipe_wdata = '0;
    logic                 issue_valid = 1'b0;
    logic [RA_W-1:0]      issue_addr = '0;
    logic                 lu_valid = 1'b0;
    logic                 lu_ready;
    logic [RA_W-1:0]      lu_waddr = '0;
    logic [XLEN-1:0]      lu_wdata = '0;
    logic                 regwrite;
    logic [RA_W-1:0]      writereg_addr;
    logic [XLEN-1:0]      writedata;
    logic [NUM_REGS-1:0]  busy_mask;
    logic                 stall_req;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .FIFO_DEPTH (2),
        .STARVE_LIM (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_wen      (pipe_wen),
        .pipe_waddr    (pipe_waddr),
        .pipe_wdata    (pipe_wdata),
        .issue_valid   (issue_valid),
        .issue_addr    (issue_addr),
        .lu_valid      (lu_valid),
        .lu_ready      (lu_ready),
        .lu_waddr      (lu_waddr),
        .lu_wdata      (lu_wdata),
        .regwrite      (regwrite),
        .writereg_addr (writereg_addr),
        .writedata     (writedata),
        .busy_mask     (busy_mask),
        .stall_req     (stall_req)
    );

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        iv;
        logic [4:0]  ia;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_rw;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic [31:0] e_busy;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic iv, input logic [4:0] ia,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_wen = pw; pipe_waddr = pa; pipe_wdata = pd;
        issue_valid = iv; issue_addr = ia;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ordering contract: a pipe write must never target a register with a pending LU write.
    always @(posedge clk) begin
        if (!rst && pipe_wen && pipe_waddr != '0 && busy_mask[pipe_waddr]) begin
            n_bad++;
            $display("FAIL order_contract: pipe write to busy x%0d at %0t", pipe_waddr, $time);
        end
    end

    initial begin
        //            pw pa    pd            iv ia  lv la    ld            rw a     d             busy          rdy  stall
        vecs[0]  = '{1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd0, 32'h0,       1, 5'd5, 32'hDEADBEEF, 32'h0,       1, 0};
        vecs[1]  = '{1, 5'd0, 32'h1,        0, 0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,        32'h0,       1, 0};
        vecs[2]  = '{0, 5'd0, 32'h0,        1, 7, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,        32'h80,      1, 0};
        vecs[3]  = '{0, 5'd0, 32'h0,        0, 0, 1, 5'd7, 32'h1234,    1, 5'd7, 32'h1234,     32'h0,       1, 0};
        vecs[4]  = '{0, 5'd0, 32'h0,        1, 9, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,        32'h200,     1, 0};
        vecs[5]  = '{0, 5'd0, 32'h0,        1, 9, 1, 5'd9, 32'hAAAA,    1, 5'd9, 32'hAAAA,     32'h200,     1, 0};
        vecs[6]  = '{0, 5'd0, 32'h0,        0, 0, 1, 5'd0, 32'h55,      0, 5'd0, 32'h0,        32'h200,     1, 0};
        vecs[7]  = '{0, 5'd0, 32'h0,        1, 3, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,        32'h208,     1, 0};
        vecs[8]  = '{0, 5'd0, 32'h0,        1, 4, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,        32'h218,     1, 0};
        vecs[9]  = '{1, 5'd1, 32'h11,       0, 0, 1, 5'd3, 32'hA,       1, 5'd1, 32'h11,       32'h218,     1, 0};
        vecs[10] = '{1, 5'd2, 32'h22,       0, 0, 1, 5'd4, 32'hB,       1, 5'd2, 32'h22,       32'h218,     0, 0};
        vecs[11] = '{1, 5'd1, 32'h33,       0, 0, 0, 5'd0, 32'h0,       1, 5'd1, 32'h33,       32'h218,     0, 0};
        vecs[12] = '{1, 5'd2, 32'h44,       0, 0, 0, 5'd0, 32'h0,       1, 5'd2, 32'h44,       32'h218,     0, 0};
        vecs[13] = '{1, 5'd1, 32'h55,       0, 0, 0, 5'd0, 32'h0,       1, 5'd1, 32'h55,       32'h218,     0, 1};
        vecs[14] = '{0, 5'd0, 32'h0,        0, 0, 0, 5'd0, 32'h0,       1, 5'd3, 32'hA,        32'h210,     1, 0};
        vecs[15] = '{0, 5'd0, 32'h0,        0, 0, 0, 5'd0, 32'h0,       1, 5'd4, 32'hB,        32'h200,     1, 0};
        vecs[16] = '{0, 5'd0, 32'h0,        0, 0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,        32'h200,     1, 0};

        // Reset state
        step();
        step();
        chk("rst_regwrite", 32'(regwrite), 32'h0);
        chk("rst_addr", 32'(writereg_addr), 32'h0);
        chk("rst_data", writedata, 32'h0);
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_ready", 32'(lu_ready), 32'h1);
        chk("rst_stall", 32'(stall_req), 32'h0);
        rst = 1'b0;

        // Mid-stream reset with two queued entries and x7 busy
        drive(0, 5'd0, 32'h0, 1, 5'd7, 0, 5'd0, 32'h0);
        step();
        drive(1, 5'd1, 32'h1, 0, 5'd0, 1, 5'd3, 32'hC3);
        step();
        drive(1, 5'd2, 32'h2, 0, 5'd0, 1, 5'd4, 32'hC4);
        step();
        drive(1, 5'd1, 32'h3, 0, 5'd0, 0, 5'd0, 32'h0);
        chk("pre_rst_busy", busy_mask, 32'h80);
        chk("pre_rst_ready", 32'(lu_ready), 32'h0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_regwrite", 32'(regwrite), 32'h0);
        chk("async_rst_busy", busy_mask, 32'h0);
        chk("async_rst_ready", 32'(lu_ready), 32'h1);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_idle", 32'(regwrite), 32'h0);
        end

        // Directed table
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].pw, vecs[i].pa, vecs[i].pd, vecs[i].iv, vecs[i].ia,
                  vecs[i].lv, vecs[i].la, vecs[i].ld);
            step();
            chk($sformatf("v%0d_regwrite", i), 32'(regwrite), 32'(vecs[i].e_rw));
            if (vecs[i].e_rw) begin
                chk($sformatf("v%0d_addr", i), 32'(writereg_addr), 32'(vecs[i].e_a));
                chk($sformatf("v%0d_data", i), writedata, vecs[i].e_d);
            end
            chk($sformatf("v%0d_busy", i), busy_mask, vecs[i].e_busy);
            chk($sformatf("v%0d_ready", i), 32'(lu_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_stall", i), 32'(stall_req), 32'(vecs[i].e_stall));
        end

        // Full FIFO with a held result: pop frees a slot, ready rises the next cycle
        drive(1, 5'd1, 32'h1, 0, 5'd0, 1, 5'd5, 32'h51);
        step();
        drive(1, 5'd2, 32'h2, 0, 5'd0, 1, 5'd6, 32'h61);
        step();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd8, 32'h81);
        chk("full_ready", 32'(lu_ready), 32'h0);
        step();
        chk("full_pop_a", writereg_addr, 5'd5);
        chk("full_pop_ready", 32'(lu_ready), 32'h1);
        step();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0);
        chk("full_pop_b", writereg_addr, 5'd6);
        step();
        chk("full_pop_c", writereg_addr, 5'd8);
        chk("full_pop_c_data", writedata, 32'h81);
        step();
        chk("drain_idle", 32'(regwrite), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
